// File: rtl/fm_pkg.sv
// Shared constants for the FM receiver: FSM state encodings and averaging depth.
package fm_pkg;

  localparam int unsigned FM_STATE_W = 2;

  typedef enum logic [FM_STATE_W-1:0] {
    FM_RX_IDLE = 2'd0,
    FM_RX_ACQ  = 2'd1,
    FM_RX_LOCK = 2'd2
  } fm_state_e;

  localparam int unsigned FM_AVG_N = 4;

endpackage

// File: rtl/fm_rx_edge.sv
// Two-flop synchroniser for the asynchronous FM input plus a registered rising-edge detect.
module fm_rx_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_fm,
  output logic o_rise
);

  logic s1, s2, s3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      o_rise <= 1'b0;
    end else begin
      s1     <= i_fm;
      s2     <= s1;
      s3     <= s2;
      o_rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/fm_rx.sv
// FM demodulator / FSK slicer: measures rising-edge periods, slices against i_thresh, tracks lock.
// Optional FM_RX_AVG_EN: report a 4-period sliding average instead of the raw period.
module fm_rx
  import fm_pkg::*;
#(
  parameter int unsigned p_cnt_sz  = 16,
  parameter int unsigned p_timeout = (2**p_cnt_sz) - 1,
  parameter int unsigned p_lock_n  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_fm,
  input  logic [p_cnt_sz-1:0] i_thresh,
  output logic [p_cnt_sz-1:0] o_period,
  output logic                o_valid,
  output logic                o_bit,
  output logic                o_lock
);

  localparam int unsigned LC_W = $clog2(p_lock_n + 1);
  localparam logic [p_cnt_sz-1:0] TMO     = p_cnt_sz'(p_timeout);
  localparam logic [p_cnt_sz-1:0] CNT_ONE = p_cnt_sz'(1);
  localparam logic [LC_W-1:0]     LOCK_N  = LC_W'(p_lock_n);

  fm_state_e           state, state_nx;
  logic                rise;
  logic [p_cnt_sz-1:0] cnt, cnt_nx;
  logic [LC_W-1:0]     lock_cnt, lock_cnt_nx, lc_inc;
  logic [p_cnt_sz-1:0] period_nx;
  logic                valid_nx, bit_nx, lock_nx;
  logic [p_cnt_sz-1:0] meas;
  logic                emit;
  logic                take, clr;

  fm_rx_edge u_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_fm   (i_fm),
    .o_rise (rise)
  );

`ifdef FM_RX_AVG_EN
  localparam int unsigned FILL_W = $clog2(FM_AVG_N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FM_AVG_N);

  logic [p_cnt_sz-1:0] win [FM_AVG_N];
  logic [FILL_W-1:0]   fill;
  logic [p_cnt_sz+1:0] avg_sum;

  // The sum includes the period being captured now, so the window is full as
  // soon as FM_AVG_N-1 older entries are held.
  always_comb begin
    avg_sum = {2'b00, cnt};
    for (int unsigned i = 0; i < FM_AVG_N - 1; i++) begin
      avg_sum = avg_sum + {2'b00, win[i]};
    end
    meas = avg_sum[p_cnt_sz+1:2];
    emit = (fill >= FILL_FULL - 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || clr) begin
      for (int unsigned i = 0; i < FM_AVG_N; i++) win[i] <= '0;
      fill <= '0;
    end else if (take) begin
      win[0] <= cnt;
      for (int unsigned i = 1; i < FM_AVG_N; i++) win[i] <= win[i-1];
      if (fill != FILL_FULL) fill <= fill + 1'b1;
    end
  end
`else
  always_comb begin
    meas = cnt;
    emit = 1'b1;
  end
`endif

  always_comb begin
    lc_inc = (lock_cnt == LOCK_N) ? lock_cnt : lock_cnt + 1'b1;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = rise ? CNT_ONE : ((cnt == '1) ? cnt : cnt + 1'b1);
    period_nx   = o_period;
    bit_nx      = o_bit;
    valid_nx    = 1'b0;
    lock_nx     = o_lock;
    lock_cnt_nx = lock_cnt;
    take        = 1'b0;
    clr         = 1'b0;
    case (state)
      FM_RX_IDLE: begin
        if (rise) state_nx = FM_RX_ACQ;
      end
      FM_RX_ACQ, FM_RX_LOCK: begin
        // A rise on the timeout cycle still closes a valid period.
        if (rise) begin
          take        = 1'b1;
          lock_cnt_nx = lc_inc;
          if (emit) begin
            valid_nx  = 1'b1;
            period_nx = meas;
            bit_nx    = (meas < i_thresh);
          end
          if (state == FM_RX_ACQ && lc_inc == LOCK_N) begin
            state_nx = FM_RX_LOCK;
            lock_nx  = 1'b1;
          end
        end else if (cnt == TMO) begin
          state_nx    = FM_RX_IDLE;
          lock_nx     = 1'b0;
          lock_cnt_nx = '0;
          clr         = 1'b1;
        end
      end
      default: state_nx = FM_RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= FM_RX_IDLE;
      cnt      <= '0;
      lock_cnt <= '0;
      o_period <= '0;
      o_valid  <= 1'b0;
      o_bit    <= 1'b0;
      o_lock   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      lock_cnt <= lock_cnt_nx;
      o_period <= period_nx;
      o_valid  <= valid_nx;
      o_bit    <= bit_nx;
      o_lock   <= lock_nx;
    end
  end

endmodule

// File: tb/tb_fm_rx.sv
// Directed self-checking bench for fm_rx (8-bit counter, timeout 255, lock after 4 periods).
module tb_fm_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       fm;
  logic [7:0] thresh;
  logic [7:0] period;
  logic       valid, bitv, lock;

  int n_cmp = 0;
  int n_err = 0;

  fm_rx #(
    .p_cnt_sz  (8),
    .p_timeout (255),
    .p_lock_n  (4)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_fm     (fm),
    .i_thresh (thresh),
    .o_period (period),
    .o_valid  (valid),
    .o_bit    (bitv),
    .o_lock   (lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge on i_fm followed by p cycles (half high, half low). A strobe seen in
  // this window reports the length of the previous window.
  task automatic win_chk(input string tag, input int p, input int exp_nv,
                         input int exp_per, input int exp_bit, input int exp_lk);
    int   nv;
    logic [7:0] per;
    logic b, lk;
    nv = 0; per = '0; b = 1'b0; lk = 1'b0;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (valid) begin
        nv++;
        per = period; b = bitv; lk = lock;
      end
      fm = (i < p / 2);
    end
    check({tag, "_nv"}, nv, exp_nv);
    if (exp_nv > 0) begin
      check({tag, "_per"}, per, exp_per);
      check({tag, "_bit"}, b, exp_bit);
      check({tag, "_lock"}, lk, exp_lk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcyc, fcyc, nv_t;
    rst = 1'b1; fm = 1'b0; thresh = 8'd80;
    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_valid",  valid,  0);
    check("rst_bit",    bitv,   0);
    check("rst_lock",   lock,   0);
    rst = 1'b0;

`ifndef FM_RX_AVG_EN
    // Steady tone, period 100, threshold 80.
    win_chk("tone1", 100, 0, 0, 0, 0);
    win_chk("tone2", 100, 1, 100, 0, 0);
    win_chk("tone3", 100, 1, 100, 0, 0);
    win_chk("tone4", 100, 1, 100, 0, 0);
    win_chk("tone5", 100, 1, 100, 0, 1);
    win_chk("tone6", 100, 1, 100, 0, 1);

    // FSK 100/60 with boundary periods 80 and 79.
    win_chk("fsk1", 60,  1, 100, 0, 1);
    win_chk("fsk2", 100, 1, 60,  1, 1);
    win_chk("fsk3", 60,  1, 100, 0, 1);
    win_chk("fsk4", 80,  1, 60,  1, 1);
    win_chk("fsk5", 79,  1, 80,  0, 1);
    win_chk("fsk6", 100, 1, 79,  1, 1);

    // Threshold all-ones; a 255-cycle period coincides with the timeout.
    thresh = 8'hFF;
    win_chk("thmax1", 255, 1, 100, 1, 1);
    win_chk("coinc",  254, 1, 255, 0, 1);
    win_chk("thmax2", 60,  1, 254, 1, 1);

    // Threshold zero, then stop the tone and wait for the lock to drop.
    thresh = 8'd0;
    vcyc = -1; fcyc = -1; nv_t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid) begin
        nv_t++;
        if (vcyc < 0) vcyc = i;
      end
      if (vcyc >= 0 && fcyc < 0 && !lock) fcyc = i;
      fm = (i < 50);
    end
    check("tmo_nvalid", nv_t, 1);
    check("tmo_delay",  fcyc - vcyc, 255);
    check("tmo_period", period, 60);
    check("tmo_bit",    bitv, 0);
    check("tmo_lock",   lock, 0);

    // Reacquire after timeout, then reset mid-measurement while locked.
    thresh = 8'd80;
    win_chk("racq1", 100, 0, 0, 0, 0);
    win_chk("racq2", 100, 1, 100, 0, 0);
    win_chk("racq3", 100, 1, 100, 0, 0);
    win_chk("racq4", 100, 1, 100, 0, 0);
    win_chk("racq5", 100, 1, 100, 0, 1);
    repeat (20) @(negedge clk);
    pulse_reset();
    check("mrst_period", period, 0);
    check("mrst_valid",  valid,  0);
    check("mrst_bit",    bitv,   0);
    check("mrst_lock",   lock,   0);
    win_chk("mrst1", 100, 0, 0, 0, 0);
    win_chk("mrst2", 100, 1, 100, 0, 0);
`endif

    // Periods 100,100,100,104: averaged build reports once with 101.
    pulse_reset();
    win_chk("avg1", 100, 0, 0, 0, 0);
`ifdef FM_RX_AVG_EN
    win_chk("avg2", 100, 0, 0, 0, 0);
    win_chk("avg3", 100, 0, 0, 0, 0);
    win_chk("avg4", 104, 0, 0, 0, 0);
    win_chk("avg5", 100, 1, 101, 0, 1);
`else
    win_chk("avg2", 100, 1, 100, 0, 0);
    win_chk("avg3", 100, 1, 100, 0, 0);
    win_chk("avg4", 104, 1, 100, 0, 0);
    win_chk("avg5", 100, 1, 104, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
